alu_cmd_framer: RTL and testbench

Parametrised, framed command interface between the UART receiver/transmitter and the ALU. It assembles multi-byte operands from checksummed command frames and commits them atomically to the ALU operand registers. On an execute frame it returns the multi-byte ALU result plus a status byte through a ready/valid transmit handshake. Malformed or stalled frames produce an error status instead of corrupting operands. It sits between the UART RX/TX and the ALU.

---
 rtl/alu_if_pkg.sv | 36 +++
 rtl/alu_resp_serializer.sv | 95 +++++++++
 rtl/alu_cmd_framer.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_cmd_framer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_if_pkg.sv
// Shared definitions for the UART-to-ALU command framer: command and status codes,
// the one-hot frame state encoding and the frame checksum step.
package alu_if_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CMD_WR_A  = 8'h00;
  localparam logic [BYTE_W-1:0] CMD_WR_B  = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_WR_OP = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_EXEC  = 8'hFF;

  localparam logic [BYTE_W-1:0] ST_OK      = 8'h00;
  localparam logic [BYTE_W-1:0] ST_BAD_CHK = 8'hE1;
  localparam logic [BYTE_W-1:0] ST_BAD_CMD = 8'hE2;
  localparam logic [BYTE_W-1:0] ST_TIMEOUT = 8'hE3;

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_PAYLOAD = 4'b0010,
    S_CHECK   = 4'b0100,
    S_RESP    = 4'b1000
  } state_e;

  typedef enum logic [1:0] {
    TGT_A    = 2'd0,
    TGT_B    = 2'd1,
    TGT_OP   = 2'd2,
    TGT_EXEC = 2'd3
  } target_e;

  function automatic logic [BYTE_W-1:0] chk_step(input logic [BYTE_W-1:0] acc,
                                                 input logic [BYTE_W-1:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/alu_resp_serializer.sv
// Response serializer: latches the ALU result, a status byte and a byte count, then
// emits result bytes LSB first followed by the status byte under valid/ready.
module alu_resp_serializer
  import alu_if_pkg::*;
#(
  parameter int NB_DATA = 16,
  parameter int CNT_W   = 2
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_res,
  input  logic [BYTE_W-1:0]  i_status,
  input  logic [CNT_W-1:0]   i_nbytes,
  input  logic               i_tx_ready,
  output logic [BYTE_W-1:0]  o_tx_data,
  output logic               o_tx_valid,
  output logic               o_last
);

  logic [NB_DATA-1:0] res_q, res_d;
  logic [BYTE_W-1:0]  status_q, status_d;
  logic [CNT_W-1:0]   nbytes_q, nbytes_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic               accept_s;

  // Byte idx of a response of n bytes: result bytes first, status byte last.
  function automatic logic [BYTE_W-1:0] pick(input logic [NB_DATA-1:0] res,
                                             input logic [BYTE_W-1:0]  st,
                                             input logic [CNT_W-1:0]   n,
                                             input logic [CNT_W-1:0]   idx);
    logic [NB_DATA-1:0] sh;
    sh = res >> {idx, 3'b000};
    if (idx < (n - CNT_W'(1))) begin
      return sh[BYTE_W-1:0];
    end else begin
      return st;
    end
  endfunction

  assign accept_s = valid_q && i_tx_ready;
  assign o_last   = accept_s && (idx_q == (nbytes_q - CNT_W'(1)));

  // Next-state logic for the response latch and byte pointer.
  always_comb begin
    res_d     = res_q;
    status_d  = status_q;
    nbytes_d  = nbytes_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    tx_data_d = tx_data_q;
    if (i_load) begin
      res_d     = i_res;
      status_d  = i_status;
      nbytes_d  = i_nbytes;
      idx_d     = {CNT_W{1'b0}};
      valid_d   = 1'b1;
      tx_data_d = pick(i_res, i_status, i_nbytes, {CNT_W{1'b0}});
    end else if (o_last) begin
      idx_d     = {CNT_W{1'b0}};
      valid_d   = 1'b0;
      tx_data_d = 8'h00;
    end else if (accept_s) begin
      idx_d     = idx_q + CNT_W'(1);
      tx_data_d = pick(res_q, status_q, nbytes_q, idx_q + CNT_W'(1));
    end else begin
      idx_d = idx_q;
    end
  end

  // Response registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      res_q     <= {NB_DATA{1'b0}};
      status_q  <= 8'h00;
      nbytes_q  <= {CNT_W{1'b0}};
      idx_q     <= {CNT_W{1'b0}};
      valid_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      res_q     <= res_d;
      status_q  <= status_d;
      nbytes_q  <= nbytes_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = valid_q;

endmodule

// File: rtl/alu_cmd_framer.sv
// Framed command interface between UART RX/TX and the ALU: assembles checksummed
// operand/opcode writes, commits them atomically and returns execute results.
module alu_cmd_framer
  import alu_if_pkg::*;
#(
  parameter int NB_DATA        = 16,
  parameter int NB_OPS         = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [BYTE_W-1:0]  i_rx_data,
  input  logic               i_rx_valid,
  input  logic [NB_DATA-1:0] i_res,
  input  logic               i_tx_ready,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OPS-1:0]  o_ops,
  output logic [BYTE_W-1:0]  o_tx_data,
  output logic               o_tx_valid,
  output logic               o_busy,
  output logic               o_err
);

  localparam int NB_BYTES = NB_DATA / BYTE_W;
  localparam int BCNT_W   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam int CNT_W    = $clog2(NB_BYTES + 2);
  localparam int TO_W     = $clog2(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  target_e            tgt_q, tgt_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [NB_DATA-1:0] stage_q, stage_d;
  logic [BYTE_W-1:0]  chk_q, chk_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OPS-1:0]  ops_q, ops_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic               ser_load_s;
  logic [BYTE_W-1:0]  ser_status_s;
  logic [CNT_W-1:0]   ser_nbytes_s;
  logic               ser_last_s;
  logic               to_hit_s;
  logic               last_pay_s;

  assign to_hit_s   = (to_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign last_pay_s = (tgt_q == TGT_OP) ? 1'b1 : (bcnt_q == BCNT_W'(NB_BYTES - 1));

  // Frame FSM: decode, payload staging, checksum, commit, timeout.
  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    bcnt_d       = bcnt_q;
    stage_d      = stage_q;
    chk_d        = chk_q;
    to_d         = to_q;
    data_a_d     = data_a_q;
    data_b_d     = data_b_q;
    ops_d        = ops_q;
    err_d        = 1'b0;
    ser_load_s   = 1'b0;
    ser_status_s = ST_OK;
    ser_nbytes_s = CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        to_d = {TO_W{1'b0}};
        if (i_rx_valid) begin
          chk_d   = i_rx_data;
          bcnt_d  = {BCNT_W{1'b0}};
          stage_d = {NB_DATA{1'b0}};
          case (i_rx_data)
            CMD_WR_A: begin
              tgt_d   = TGT_A;
              state_d = S_PAYLOAD;
            end
            CMD_WR_B: begin
              tgt_d   = TGT_B;
              state_d = S_PAYLOAD;
            end
            CMD_WR_OP: begin
              tgt_d   = TGT_OP;
              state_d = S_PAYLOAD;
            end
            CMD_EXEC: begin
              tgt_d   = TGT_EXEC;
              state_d = S_CHECK;
            end
            default: begin
              ser_load_s   = 1'b1;
              ser_status_s = ST_BAD_CMD;
              err_d        = 1'b1;
              state_d      = S_RESP;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (i_rx_valid) begin
          to_d  = {TO_W{1'b0}};
          chk_d = chk_step(chk_q, i_rx_data);
          // Operand bytes arrive LSB first, so shift each new byte in at the top.
          if (tgt_q == TGT_OP) begin
            stage_d = NB_DATA'(i_rx_data);
          end else begin
            stage_d = (stage_q >> BYTE_W) | (NB_DATA'(i_rx_data) << (NB_DATA - BYTE_W));
          end
          if (last_pay_s) begin
            bcnt_d  = {BCNT_W{1'b0}};
            state_d = S_CHECK;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end else if (to_hit_s) begin
          to_d         = {TO_W{1'b0}};
          stage_d      = {NB_DATA{1'b0}};
          ser_load_s   = 1'b1;
          ser_status_s = ST_TIMEOUT;
          err_d        = 1'b1;
          state_d      = S_RESP;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_CHECK: begin
        if (i_rx_valid) begin
          to_d    = {TO_W{1'b0}};
          stage_d = {NB_DATA{1'b0}};
          if (i_rx_data == chk_q) begin
            state_d = S_IDLE;
            case (tgt_q)
              TGT_A:  data_a_d = stage_q;
              TGT_B:  data_b_d = stage_q;
              TGT_OP: ops_d    = stage_q[NB_OPS-1:0];
              TGT_EXEC: begin
                ser_load_s   = 1'b1;
                ser_status_s = ST_OK;
                ser_nbytes_s = CNT_W'(NB_BYTES + 1);
                state_d      = S_RESP;
              end
              default: state_d = S_IDLE;
            endcase
          end else begin
            ser_load_s   = 1'b1;
            ser_status_s = ST_BAD_CHK;
            err_d        = 1'b1;
            state_d      = S_RESP;
          end
        end else if (to_hit_s) begin
          to_d         = {TO_W{1'b0}};
          stage_d      = {NB_DATA{1'b0}};
          ser_load_s   = 1'b1;
          ser_status_s = ST_TIMEOUT;
          err_d        = 1'b1;
          state_d      = S_RESP;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_RESP: begin
        // Incoming RX bytes are ignored until the response has drained.
        if (ser_last_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Frame state, staging and operand registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      tgt_q    <= TGT_A;
      bcnt_q   <= {BCNT_W{1'b0}};
      stage_q  <= {NB_DATA{1'b0}};
      chk_q    <= 8'h00;
      to_q     <= {TO_W{1'b0}};
      data_a_q <= {NB_DATA{1'b0}};
      data_b_q <= {NB_DATA{1'b0}};
      ops_q    <= {NB_OPS{1'b0}};
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      bcnt_q   <= bcnt_d;
      stage_q  <= stage_d;
      chk_q    <= chk_d;
      to_q     <= to_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      ops_q    <= ops_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  alu_resp_serializer #(
    .NB_DATA (NB_DATA),
    .CNT_W   (CNT_W)
  ) u_resp (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_load     (ser_load_s),
    .i_res      (i_res),
    .i_status   (ser_status_s),
    .i_nbytes   (ser_nbytes_s),
    .i_tx_ready (i_tx_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .o_last     (ser_last_s)
  );

  assign o_data_a = data_a_q;
  assign o_data_b = data_b_q;
  assign o_ops    = ops_q;
  assign o_busy   = busy_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_alu_cmd_framer.sv
// Directed bench for alu_cmd_framer (NB_DATA=16, TIMEOUT_CYCLES=20) with
// hand-computed frames, checksums and responses.
module tb_alu_cmd_framer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] res;
  logic        tx_ready;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic [5:0]  ops;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;

  alu_cmd_framer #(
    .NB_DATA        (16),
    .NB_OPS         (6),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .i_res      (res),
    .i_tx_ready (tx_ready),
    .o_data_a   (data_a),
    .o_data_b   (data_b),
    .o_ops      (ops),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .o_busy     (busy),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: presents one byte for one clock, returns at the next negedge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    res      = 16'h0000;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data_a", 32'(data_a), 32'h0);
    chk("rst_data_b", 32'(data_b), 32'h0);
    chk("rst_ops", 32'(ops), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write A: 00 34 12 26
    send(8'h00); send(8'h34); send(8'h12);
    chk("wa_busy_mid", 32'(busy), 32'h1);
    chk("wa_a_before_chk", 32'(data_a), 32'h0);
    send(8'h26);
    chk("wa_data_a", 32'(data_a), 32'h1234);
    chk("wa_no_tx", 32'(tx_valid), 32'h0);
    chk("wa_no_err", 32'(err), 32'h0);
    chk("wa_idle", 32'(busy), 32'h0);

    // Execute: FF FF with res=ABCD, ready high
    res = 16'hABCD;
    send(8'hFF);
    chk("ex_no_tx_early", 32'(tx_valid), 32'h0);
    send(8'hFF);
    res = 16'h0000;
    chk("ex_v0", 32'(tx_valid), 32'h1);
    chk("ex_b0", 32'(tx_data), 32'hCD);
    @(negedge clk);
    chk("ex_v1", 32'(tx_valid), 32'h1);
    chk("ex_b1", 32'(tx_data), 32'hAB);
    @(negedge clk);
    chk("ex_v2", 32'(tx_valid), 32'h1);
    chk("ex_b2", 32'(tx_data), 32'h00);
    chk("ex_busy_last", 32'(busy), 32'h1);
    @(negedge clk);
    chk("ex_done_valid", 32'(tx_valid), 32'h0);
    chk("ex_done_busy", 32'(busy), 32'h0);

    // Bad checksum on write B: 01 55 00 00 (correct CHK would be 54)
    send(8'h01); send(8'h55); send(8'h00); send(8'h00);
    chk("bc_valid", 32'(tx_valid), 32'h1);
    chk("bc_status", 32'(tx_data), 32'hE1);
    chk("bc_err", 32'(err), 32'h1);
    chk("bc_data_b", 32'(data_b), 32'h0);
    @(negedge clk);
    chk("bc_err_pulse", 32'(err), 32'h0);
    chk("bc_drained", 32'(tx_valid), 32'h0);
    chk("bc_idle", 32'(busy), 32'h0);

    // Bad command with 10 cycles of backpressure; a stray byte during RESP is dropped
    tx_ready = 1'b0;
    send(8'h07);
    chk("cmd_valid", 32'(tx_valid), 32'h1);
    chk("cmd_status", 32'(tx_data), 32'hE2);
    chk("cmd_err", 32'(err), 32'h1);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) send(8'h00);
      else @(negedge clk);
      chk("bp_valid", 32'(tx_valid), 32'h1);
      chk("bp_stable", 32'(tx_data), 32'hE2);
      chk("bp_err_low", 32'(err), 32'h0);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    chk("bp_drained", 32'(tx_valid), 32'h0);
    chk("bp_idle", 32'(busy), 32'h0);
    send(8'h02); send(8'h05); send(8'h07);
    chk("op_ops", 32'(ops), 32'h05);
    chk("op_no_tx", 32'(tx_valid), 32'h0);

    // Timeout: 00 34 then silence; response E3 on the 20th idle edge
    send(8'h00); send(8'h34);
    repeat (19) @(negedge clk);
    chk("to_not_yet", 32'(tx_valid), 32'h0);
    @(negedge clk);
    chk("to_valid", 32'(tx_valid), 32'h1);
    chk("to_status", 32'(tx_data), 32'hE3);
    chk("to_err", 32'(err), 32'h1);
    chk("to_data_a", 32'(data_a), 32'h1234);
    @(negedge clk);
    chk("to_drained", 32'(tx_valid), 32'h0);

    // Byte arriving on the would-be timeout edge wins: 00 CD .. AB 66
    send(8'h00); send(8'hCD);
    repeat (19) @(negedge clk);
    send(8'hAB);
    chk("tw_no_tx", 32'(tx_valid), 32'h0);
    chk("tw_no_err", 32'(err), 32'h0);
    send(8'h66);
    chk("tw_data_a", 32'(data_a), 32'hABCD);

    // Reset between 2nd and 3rd byte of a write-A frame
    send(8'h00); send(8'h78);
    rst_n = 1'b0;
    #1;
    chk("mr_data_a", 32'(data_a), 32'h0);
    chk("mr_ops", 32'(ops), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_tx_valid", 32'(tx_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h00); send(8'h78); send(8'h56); send(8'h2E);
    chk("mr_new_a", 32'(data_a), 32'h5678);
    chk("mr_b_zero", 32'(data_b), 32'h0);
    chk("mr_no_tx", 32'(tx_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
